// File: rtl/hps_rst_pkg.sv
// Shared types and helpers for the HPS reset-request sequencer.
package hps_rst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0] RST_COLD  = 2'd0;
    localparam logic [1:0] RST_WARM  = 2'd1;
    localparam logic [1:0] RST_DEBUG = 2'd2;
    localparam logic [1:0] RST_NONE  = 2'd3;

    localparam int unsigned NUM_REQ   = 3;
    localparam int unsigned REQ_COLD  = 0;
    localparam int unsigned REQ_WARM  = 1;
    localparam int unsigned REQ_DEBUG = 2;

    // Fixed priority: cold > warm > debug.
    function automatic logic [1:0] prio_grant(input logic [NUM_REQ-1:0] pend);
        if (pend[REQ_COLD])       return RST_COLD;
        else if (pend[REQ_WARM])  return RST_WARM;
        else if (pend[REQ_DEBUG]) return RST_DEBUG;
        else                      return RST_NONE;
    endfunction

    // Pending bits retired by a grant; cold subsumes warm and debug.
    function automatic logic [NUM_REQ-1:0] grant_clear(input logic [1:0] g);
        case (g)
            RST_COLD:  return 3'b111;
            RST_WARM:  return 3'b010;
            RST_DEBUG: return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/rst_req_sync_edge.sv
// 2-FF synchronizer with a delayed copy for single-cycle rising-edge detection.
module rst_req_sync_edge #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/hps_reset_sequencer.sv
// Queues cold/warm/debug reset requests and issues one prioritized active-low pulse at a time.
// Optional statistics outputs (pulse_cnt, coalesced) under `HPS_RST_SEQ_STATS_EN.
module hps_reset_sequencer
    import hps_rst_pkg::*;
#(
    parameter int unsigned COLD_PULSE  = 6,
    parameter int unsigned WARM_PULSE  = 2,
    parameter int unsigned DEBUG_PULSE = 32,
    parameter int unsigned HOLDOFF     = 50000,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    output logic               cold_reset_req_n,
    output logic               warm_reset_req_n,
    output logic               debug_reset_req_n,
    output logic               busy,
    output logic [NUM_REQ-1:0] pending,
    output logic [1:0]         last_grant
`ifdef HPS_RST_SEQ_STATS_EN
    ,
    output logic [7:0]         pulse_cnt,
    output logic               coalesced
`endif
);

    localparam logic [CNT_WIDTH-1:0] COLD_LOAD  = CNT_WIDTH'(COLD_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] WARM_LOAD  = CNT_WIDTH'(WARM_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] DEBUG_LOAD = CNT_WIDTH'(DEBUG_PULSE - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  = CNT_WIDTH'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    logic [NUM_REQ-1:0]   rise;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_n_q, req_n_d;
    logic [NUM_REQ-1:0]   pend_d;
    logic [NUM_REQ-1:0]   pend_clr;
    logic [1:0]           last_d;
    logic [1:0]           grant;

    rst_req_sync_edge #(.WIDTH(NUM_REQ)) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (req_in),
        .rise_c (rise)
    );

    // Next-state, counter, pulse and pending-queue logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_n_d  = req_n_q;
        last_d   = last_grant;
        pend_clr = '0;
        grant    = prio_grant(pending);
        case (state_q)
            ST_IDLE: begin
                if (pending != '0) begin
                    state_d  = ST_PULSE;
                    last_d   = grant;
                    pend_clr = grant_clear(grant);
                    case (grant)
                        RST_COLD: begin
                            cnt_d   = COLD_LOAD;
                            req_n_d = 3'b110;
                        end
                        RST_WARM: begin
                            cnt_d   = WARM_LOAD;
                            req_n_d = 3'b101;
                        end
                        default: begin
                            cnt_d   = DEBUG_LOAD;
                            req_n_d = 3'b011;
                        end
                    endcase
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    req_n_d = '1;
                    if (HOLDOFF > 0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_WIDTH'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CNT_WIDTH'(1);
            end
            default: begin
                state_d = ST_IDLE;
                req_n_d = '1;
            end
        endcase
        // A rise coinciding with its own grant survives the clear.
        pend_d = (pending & ~pend_clr) | rise;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_n_q    <= '1;
            pending    <= '0;
            last_grant <= RST_NONE;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_n_q    <= req_n_d;
            pending    <= pend_d;
            last_grant <= last_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

    assign cold_reset_req_n  = req_n_q[REQ_COLD];
    assign warm_reset_req_n  = req_n_q[REQ_WARM];
    assign debug_reset_req_n = req_n_q[REQ_DEBUG];

`ifdef HPS_RST_SEQ_STATS_EN
    logic grant_now;
    logic coal_now;

    // Coalesce: a rise onto a still-queued bit, or queued bits swallowed by a cold grant.
    assign grant_now = (state_q == ST_IDLE) && (pending != '0);
    assign coal_now  = ((rise & pending & ~pend_clr) != '0) ||
                       (grant_now && (grant == RST_COLD) &&
                        ((pending & 3'b110) != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_cnt <= '0;
            coalesced <= 1'b0;
        end else begin
            if (grant_now) pulse_cnt <= pulse_cnt + 8'd1;
            if (coal_now)  coalesced <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hps_reset_sequencer.sv
// Bench for hps_reset_sequencer: two instances (holdoff 8 and holdoff 0) against an interval-based reference model.
module tb_hps_reset_sequencer;

    localparam int unsigned HOLD_A = 8;
    localparam int unsigned HOLD_B = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req_in;
    logic [2:0] rn_a, rn_b;
    logic       busy_a, busy_b;
    logic [2:0] pend_a, pend_b;
    logic [1:0] last_a, last_b;
`ifdef HPS_RST_SEQ_STATS_EN
    logic [7:0] pcnt_a, pcnt_b;
    logic       coal_a, coal_b;
`endif

    always #10 clk = ~clk;

    hps_reset_sequencer #(.HOLDOFF(HOLD_A)) dut_a (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_in            (req_in),
        .cold_reset_req_n  (rn_a[0]),
        .warm_reset_req_n  (rn_a[1]),
        .debug_reset_req_n (rn_a[2]),
        .busy              (busy_a),
        .pending           (pend_a),
        .last_grant        (last_a)
`ifdef HPS_RST_SEQ_STATS_EN
        ,
        .pulse_cnt         (pcnt_a),
        .coalesced         (coal_a)
`endif
    );

    hps_reset_sequencer #(.HOLDOFF(HOLD_B)) dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_in            (req_in),
        .cold_reset_req_n  (rn_b[0]),
        .warm_reset_req_n  (rn_b[1]),
        .debug_reset_req_n (rn_b[2]),
        .busy              (busy_b),
        .pending           (pend_b),
        .last_grant        (last_b)
`ifdef HPS_RST_SEQ_STATS_EN
        ,
        .pulse_cnt         (pcnt_b),
        .coalesced         (coal_b)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] actual=%0d expected=%0d (t=%0t)", name, idx, act, exp, $time);
        end
    endtask

    // Reference model: each pulse is an interval [start, start+len) of edge indices,
    // followed by a holdoff interval; the next grant may happen once the IDLE cycle is reached.
    int         plen[3];
    int         hold[2];
    logic [2:0] q1, q2, q3;
    int         cyc;
    logic [2:0] m_pend[2];
    int         m_last[2], m_gstart[2], m_glen[2], m_gtype[2], m_can[2], m_pulses[2];
    bit         m_coal[2];
    logic [2:0] prev_rn[2];
    int         falls[2][3];
    int         lows[2][3];

    function automatic void model_reset();
        q1 = '0; q2 = '0; q3 = '0;
        cyc = 0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m]   = '0;
            m_last[m]   = 3;
            m_gstart[m] = -1000000;
            m_glen[m]   = 0;
            m_gtype[m]  = 3;
            m_can[m]    = 0;
        end
    endfunction

    function automatic void stats_reset();
        for (int m = 0; m < 2; m++) begin
            m_pulses[m] = 0;
            m_coal[m]   = 1'b0;
        end
    endfunction

    function automatic void counters_reset();
        for (int m = 0; m < 2; m++) begin
            prev_rn[m] = 3'b111;
            for (int t = 0; t < 3; t++) begin
                falls[m][t] = 0;
                lows[m][t]  = 0;
            end
        end
    endfunction

    function automatic void model_step();
        logic [2:0] rise;
        logic [2:0] clr;
        int         g;
        rise = q2 & ~q3;
        for (int m = 0; m < 2; m++) begin
            clr = '0;
            if (cyc >= m_can[m] && m_pend[m] != '0) begin
                g = m_pend[m][0] ? 0 : (m_pend[m][1] ? 1 : 2);
                m_last[m]   = g;
                m_gtype[m]  = g;
                m_gstart[m] = cyc;
                m_glen[m]   = plen[g];
                m_can[m]    = cyc + plen[g] + hold[m] + 1;
                m_pulses[m]++;
                if (g == 0 && m_pend[m][2:1] != 2'b00) m_coal[m] = 1'b1;
                clr = (g == 0) ? 3'b111 : 3'(1 << g);
            end
            if ((rise & m_pend[m] & ~clr) != '0) m_coal[m] = 1'b1;
            m_pend[m] = (m_pend[m] & ~clr) | rise;
        end
        q3 = q2; q2 = q1; q1 = req_in;
        cyc++;
    endfunction

    task automatic compare_all();
        logic [2:0] rn, pd, exp_rn;
        logic       bz, exp_bz;
        logic [1:0] lg;
        int         now;
        now = cyc - 1;
        for (int m = 0; m < 2; m++) begin
            if (m == 0) begin rn = rn_a; bz = busy_a; pd = pend_a; lg = last_a; end
            else        begin rn = rn_b; bz = busy_b; pd = pend_b; lg = last_b; end
            exp_rn = 3'b111;
            if (rst_n && m_gtype[m] < 3 && now >= m_gstart[m] && now < m_gstart[m] + m_glen[m])
                exp_rn[m_gtype[m]] = 1'b0;
            exp_bz = rst_n && now >= m_gstart[m] && now < m_gstart[m] + m_glen[m] + hold[m];
            check("req_n", m, int'(rn), int'(exp_rn));
            check("busy", m, int'(bz), int'(exp_bz));
            check("pending", m, int'(pd), int'(m_pend[m]));
            check("last_grant", m, int'(lg), m_last[m]);
            check("one_low", m, int'($countones(~rn) <= 1), 1);
`ifdef HPS_RST_SEQ_STATS_EN
            if (m == 0) begin
                check("pulse_cnt", m, int'(pcnt_a), m_pulses[m] % 256);
                check("coalesced", m, int'(coal_a), int'(m_coal[m]));
            end else begin
                check("pulse_cnt", m, int'(pcnt_b), m_pulses[m] % 256);
                check("coalesced", m, int'(coal_b), int'(m_coal[m]));
            end
`endif
            for (int t = 0; t < 3; t++) begin
                if (!rn[t]) lows[m][t]++;
                if (prev_rn[m][t] && !rn[t]) falls[m][t]++;
            end
            prev_rn[m] = rn;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        req_in = '0;
        rst_n  = 1'b0;
        model_reset();
        stats_reset();
        counters_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0] req;
        int         hold_cycles;
        int         exp_last;
        logic [2:0] exp_mask;
    } vec_t;

    vec_t vecs[7];

    initial begin
        plen[0] = 6; plen[1] = 2; plen[2] = 32;
        hold[0] = HOLD_A; hold[1] = HOLD_B;
        rst_n  = 1'b0;
        req_in = '0;

        vecs[0] = '{req: 3'b010, hold_cycles: 10,  exp_last: 1, exp_mask: 3'b010};
        vecs[1] = '{req: 3'b111, hold_cycles: 1,   exp_last: 0, exp_mask: 3'b001};
        vecs[2] = '{req: 3'b100, hold_cycles: 40,  exp_last: 2, exp_mask: 3'b100};
        vecs[3] = '{req: 3'b001, hold_cycles: 5,   exp_last: 0, exp_mask: 3'b001};
        vecs[4] = '{req: 3'b110, hold_cycles: 3,   exp_last: 2, exp_mask: 3'b110};
        vecs[5] = '{req: 3'b101, hold_cycles: 2,   exp_last: 0, exp_mask: 3'b001};
        vecs[6] = '{req: 3'b011, hold_cycles: 100, exp_last: 0, exp_mask: 3'b001};

        // Reset state
        do_reset();
        check("rst_req_n", 0, int'(rn_a), 7);
        check("rst_last", 0, int'(last_a), 3);
        check("rst_busy", 0, int'(busy_a), 0);

        // Table-driven single-shot patterns
        for (int v = 0; v < 7; v++) begin
            do_reset();
            req_in = vecs[v].req;
            for (int i = 0; i < 200; i++) begin
                if (i == vecs[v].hold_cycles) req_in = '0;
                tick();
            end
            for (int m = 0; m < 2; m++) begin
                check("vec_last", v, (m == 0) ? int'(last_a) : int'(last_b), vecs[v].exp_last);
                check("vec_pend", v, (m == 0) ? int'(pend_a) : int'(pend_b), 0);
                for (int t = 0; t < 3; t++) begin
                    check("vec_falls", v * 10 + t, falls[m][t], int'(vecs[v].exp_mask[t]));
                    check("vec_lows", v * 10 + t, lows[m][t], vecs[v].exp_mask[t] ? plen[t] : 0);
                end
            end
        end

        // Warm alone: exact latency, width and busy window
        do_reset();
        req_in = 3'b010;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) req_in = '0;
            tick();
            check("warm_n_at", i, int'(rn_a[1]), (i == 3 || i == 4) ? 0 : 1);
            check("warm_busy_at", i, int'(busy_a), (i >= 3 && i <= 12) ? 1 : 0);
        end
        check("warm_last", 0, int'(last_a), 1);

        // Queued priority: warm arrives during debug pulse
        do_reset();
        req_in = 3'b100;
        for (int i = 0; i < 60; i++) begin
            if (i == 5) req_in = 3'b110;
            tick();
            if (i == 34) check("dbg_low_end", 0, int'(rn_a[2]), 0);
            if (i == 35) check("dbg_high", 0, int'(rn_a[2]), 1);
            if (i == 43) check("warm_wait", 0, int'(rn_a[1]), 1);
            if (i == 44 || i == 45) check("warm_low", i, int'(rn_a[1]), 0);
            if (i == 46) check("warm_done", 0, int'(rn_a[1]), 1);
            if (i == 36 || i == 37) check("warm_low_h0", i, int'(rn_b[1]), 0);
        end
        req_in = '0;

        // Coalesce: three debug rises during warm pulse+holdoff
        do_reset();
        for (int i = 0; i < 70; i++) begin
            req_in[1] = (i < 10);
            req_in[2] = (i == 3 || i == 4 || i == 7 || i == 8 || i == 11 || i == 12);
            tick();
        end
        check("coal_dbg_falls", 0, falls[0][2], 1);
        check("coal_warm_falls", 0, falls[0][1], 1);
`ifdef HPS_RST_SEQ_STATS_EN
        check("coal_flag", 0, int'(coal_a), 1);
        check("coal_pcnt", 0, int'(pcnt_a), 2);
`endif

        // Reset mid-pulse
        do_reset();
        req_in = 3'b001;
        for (int i = 0; i < 6; i++) tick();
        check("mid_cold_low", 0, int'(rn_a[0]), 0);
        req_in = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_cold_a", 0, int'(rn_a[0]), 1);
        check("mid_cold_b", 0, int'(rn_b[0]), 1);
        check("mid_pend", 0, int'(pend_a), 0);
        check("mid_last", 0, int'(last_a), 3);
        check("mid_busy", 0, int'(busy_a), 0);
        model_reset();
        stats_reset();
        @(negedge clk);
        rst_n = 1'b1;
        counters_reset();
        for (int i = 0; i < 40; i++) tick();
        check("mid_no_pulse_a", 0, falls[0][0] + falls[0][1] + falls[0][2], 0);
        check("mid_no_pulse_b", 0, falls[1][0] + falls[1][1] + falls[1][2], 0);

        // Holdoff 0, held level: one cold pulse, busy drops as pulse ends
        do_reset();
        req_in = 3'b001;
        for (int i = 0; i < 120; i++) begin
            if (i == 100) req_in = '0;
            tick();
            if (i >= 3 && i <= 8) check("h0_cold_low", i, int'(rn_b[0]), 0);
            if (i == 8) check("h0_busy_hi", i, int'(busy_b), 1);
            if (i == 9) begin
                check("h0_busy_lo", i, int'(busy_b), 0);
                check("h0_cold_hi", i, int'(rn_b[0]), 1);
            end
        end
        check("h0_one_pulse", 0, falls[1][0], 1);
        check("h8_one_pulse", 0, falls[0][0], 1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req_in = 3'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
